// File: rtl/instr_encoder.sv
// RV64I instruction encoder: turns decoded fields into 32-bit words for instruction memory,
// with a one-deep registered output stage, a byte-address counter and an immediate range check.
module instr_encoder #(
  parameter logic [63:0] BASE_ADDR = 64'h0
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [1:0]  in_fmt,
  input  logic [1:0]  in_funct,
  input  logic [4:0]  in_rd,
  input  logic [4:0]  in_rs1,
  input  logic [4:0]  in_rs2,
  input  logic [63:0] in_imm,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [63:0] out_addr,
  output logic        err
);

  typedef enum logic [1:0] {
    FMT_LOAD   = 2'b00,
    FMT_STORE  = 2'b01,
    FMT_RTYPE  = 2'b10,
    FMT_BRANCH = 2'b11
  } fmt_e;

  logic        r_valid;
  logic [31:0] r_instr;
  logic [63:0] r_addr;
  logic [63:0] r_cnt;
  logic        r_err;

  logic        w_accept;
  logic        w_drain;
  logic        w_legal;
  logic [63:0] w_nextCnt;
  logic [31:0] w_enc;
  logic [6:0]  w_funct7;
  logic [2:0]  w_f3;
  fmt_e        w_fmt;

  assign w_fmt     = fmt_e'(in_fmt);
  assign in_ready  = !r_valid || out_ready;
  assign w_accept  = in_valid && in_ready;
  assign w_drain   = r_valid && out_ready;
  assign w_nextCnt = w_drain ? r_cnt + 64'd4 : r_cnt;

  // Sign-extension check: all upper bits must match the top bit of the encodable field.
  always_comb begin
    w_legal = 1'b1;
    case (w_fmt)
      FMT_LOAD, FMT_STORE: w_legal = (&in_imm[63:11]) || !(|in_imm[63:11]);
      FMT_BRANCH:          w_legal = ((&in_imm[63:12]) || !(|in_imm[63:12])) && !in_imm[0];
      default:             w_legal = 1'b1;
    endcase
  end

  always_comb begin
    w_funct7 = (in_funct == 2'b01) ? 7'b0100000 : 7'b0000000;
    w_f3     = 3'b000;
    case (in_funct)
      2'b10:   w_f3 = 3'b111;
      2'b11:   w_f3 = 3'b110;
      default: w_f3 = 3'b000;
    endcase
    w_enc = 32'h0;
    case (w_fmt)
      FMT_LOAD:   w_enc = {in_imm[11:0], in_rs1, 3'b011, in_rd, 7'b0000011};
      FMT_STORE:  w_enc = {in_imm[11:5], in_rs2, in_rs1, 3'b011, in_imm[4:0], 7'b0100011};
      FMT_RTYPE:  w_enc = {w_funct7, in_rs2, in_rs1, w_f3, in_rd, 7'b0110011};
      FMT_BRANCH: w_enc = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, 3'b000,
                           in_imm[4:1], in_imm[11], 7'b1100011};
      default:    w_enc = 32'h0;
    endcase
  end

  // Illegal requests consume the handshake but leave the output stage draining as if idle.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_valid <= 1'b0;
      r_instr <= 32'h0;
      r_addr  <= BASE_ADDR;
      r_cnt   <= BASE_ADDR;
      r_err   <= 1'b0;
    end else begin
      r_cnt <= w_nextCnt;
      if (w_accept && w_legal) begin
        r_valid <= 1'b1;
        r_instr <= w_enc;
        r_addr  <= w_nextCnt;
      end else if (w_drain) begin
        r_valid <= 1'b0;
      end
      if (w_accept && !w_legal) begin
        r_err <= 1'b1;
      end
    end
  end

  assign out_valid = r_valid;
  assign out_instr = r_instr;
  assign out_addr  = r_addr;
  assign err       = r_err;

endmodule
